irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Interrupt controller directly downstream of the timer unit and other irq sources.
//  Latches single-cycle irq pulses into pending bits and masks them with an enable register.
//  Presents one registered level irq to the CPU, with claim/complete handshake over the
//  a/d/we/spo bus. Source 0 is wired to the timer irq output.
// PARAMETERS
//  NSRC   4   number of irq sources, 1..31; source i has id i+1, id 0 = none
// PORTS
//  clk      in   1     clock
//  rst      in   1     reset, synchronous, active-high
//  a        in   3     register select
//  d        in   32    write data (byte-swapped bus order)
//  we       in   1     write strobe
//  re       in   1     read strobe; qualifies read side effects (CLAIM only)
//  spo      out  32    combinational read data (byte-swapped bus order)
//  irq_src  in   NSRC  source irq lines (timer = bit 0)
//  irq      out  1     registered interrupt request to CPU
// BEHAVIOUR
//  - Bus byte order: value written = {d[7:0],d[15:8],d[23:16],d[31:24]}; spo swapped the same way.
//  - Registers:
//    - a=000 PENDING: R; W1C.
//    - a=001 ENABLE: RW, reset 0.
//    - a=010 CLAIM (read with re) / COMPLETE (write id).
//    - a=011 STATUS: [4:0] in-service id, [8] irq.
//    - others: read 0, writes ignored.
//  - Edge detect per source: pending[i] set when irq_src[i]=1 and previous sample was 0.
//    Edge detect registers reset to 0.
//  - Priority: lowest index wins. best = lowest i with pending[i]&enable[i].
//  - FSM, reset to IDLE:
//    - IDLE: when any pending&enable, go to ASSERT; irq=1 from the next cycle.
//    - ASSERT: CLAIM read (a=010, re=1) returns best id and clears that pending bit.
//      Latches isvc=id, moves to SERVICE, irq=0 next cycle.
//      If pending&enable drops to 0 (W1C or ENABLE cleared), return to IDLE, irq=0 next cycle.
//    - SERVICE: irq held 0 (no nesting). COMPLETE write with d==isvc clears isvc and moves to IDLE.
//      A mismatched id is ignored.
//  - CLAIM read in IDLE or SERVICE returns 0 and has no side effect.
//  - spo for CLAIM is combinational: best id in ASSERT, 0 otherwise.
//  - Simultaneous events:
//    - A new edge on bit i in the same cycle as a W1C or claim of bit i leaves pending[i]=1 (set wins).
//    - Disabled sources still latch pending; they raise irq once enabled.
//  - Reset values: irq=0, spo reads 0 for PENDING/ENABLE/STATUS; state=IDLE, isvc=0.
//    rst asserted mid-SERVICE returns to IDLE in one cycle with all pending bits dropped.
// CONFIGURATION
//  IRQ_LEVEL_MODE_EN
//  - Defined: adds a=100 TRIGMODE (RW, reset 0). Bit i=1 makes source i level-triggered:
//    pending[i] follows irq_src[i] each cycle, and W1C/claim clear of that bit has no
//    effect while the line stays high.
//  - Undefined: every source is edge-triggered, and a=100 reads 0 with writes ignored.
// TESTING
//  1. Reset, ENABLE=swap(32'h1), pulse irq_src[0] 1 cycle -> PENDING reads swap(1); irq=1 two cycles after the pulse.
//  2. Claim in ASSERT (re, a=010) -> spo=swap(1), irq=0 next cycle, STATUS=swap(1).
//     Write COMPLETE d=swap(1) -> IDLE, STATUS=0.
//  3. Pulse src 2 and src 1 in the same cycle, both enabled -> claim returns 2 (id of src 1).
//     Complete -> irq reasserts; claim returns 3.
//  4. In SERVICE, pulse src 0 and write COMPLETE d=swap(5) -> ignored, irq stays 0.
//     Then write COMPLETE with the correct id -> irq=1.
//  5. W1C PENDING bit 0 in the same cycle as a new src 0 edge -> PENDING bit 0 stays 1.
//     rst mid-SERVICE -> all registers 0, irq=0.
//  6. With IRQ_LEVEL_MODE_EN: TRIGMODE=swap(1), hold src 0 high, claim+complete
//     -> irq reasserts. Drop the line -> PENDING=0, irq drops.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: interrupt controller downstream of the timer and other irq sources.
// Source irq pulses are edge-detected into pending bits and masked by ENABLE.
// The lowest-index pending+enabled source is presented to the CPU as one
// registered level irq, with a claim/complete handshake over the a/d/we/spo bus.
//
// Optional feature macro: IRQ_LEVEL_MODE_EN adds the TRIGMODE register at a=100.
// Without it, every source is edge-triggered and a=100 reads 0.
//
// Ports:
//   clk      in   1     clock
//   rst      in   1     synchronous active-high reset
//   a        in   3     register select (0 PENDING, 1 ENABLE, 2 CLAIM/COMPLETE,
//                       3 STATUS, 4 TRIGMODE)
//   d        in   32    write data, byte-swapped bus order
//   we       in   1     write strobe
//   re       in   1     read strobe (qualifies the CLAIM side effect)
//   spo      out  32    combinational read data, byte-swapped bus order
//   irq_src  in   NSRC  source irq lines (bit 0 = timer)
//   irq      out  1     registered interrupt request to the CPU
module irq_arbiter #(
  parameter int unsigned NSRC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            re,
  output logic [31:0]     spo,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq
);

  localparam int unsigned IDW = 5;

  localparam logic [2:0] A_PENDING  = 3'd0;
  localparam logic [2:0] A_ENABLE   = 3'd1;
  localparam logic [2:0] A_CLAIM    = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_TRIGMODE = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_en;
  logic [NSRC-1:0] r_prev;
  logic [IDW-1:0]  r_isvc;
  logic            r_irq;

  logic [31:0]     w_wdata;
  logic [31:0]     w_rdata;
  logic [NSRC-1:0] w_act;
  logic [NSRC-1:0] w_best_oh;
  logic [IDW-1:0]  w_best_id;
  logic            w_any;
  logic            w_claim;
  logic            w_complete;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_pend_next;
  logic            w_irq_next;
  logic [IDW-1:0]  w_isvc_next;

`ifdef IRQ_LEVEL_MODE_EN
  logic [NSRC-1:0] r_trig;
`endif

  // Bus is byte-swapped in both directions.
  assign w_wdata = {d[7:0], d[15:8], d[23:16], d[31:24]};
  assign spo     = {w_rdata[7:0], w_rdata[15:8], w_rdata[23:16], w_rdata[31:24]};

  assign w_act     = r_pend & r_en;
  assign w_any     = (w_act != '0);
  // Isolate the lowest set bit: lowest index has priority.
  assign w_best_oh = w_act & (~w_act + NSRC'(1));

  // Id of the lowest-index active source (0 when none).
  always_comb begin
    w_best_id = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (w_act[i]) w_best_id = IDW'(i + 1);
    end
  end

  assign w_claim    = (r_state == S_ASSERT) && re && (a == A_CLAIM) && w_any;
  assign w_complete = (r_state == S_SERVICE) && we && (a == A_CLAIM) &&
                      (w_wdata == 32'(r_isvc));

  // Pending update: clears first, then new edges, so a same-cycle edge wins.
  always_comb begin
    w_clr = '0;
    if (we && (a == A_PENDING)) w_clr = w_wdata[NSRC-1:0];
    if (w_claim)                w_clr = w_clr | w_best_oh;
    w_edge      = irq_src & ~r_prev;
    w_pend_next = (r_pend & ~w_clr) | w_edge;
`ifdef IRQ_LEVEL_MODE_EN
    // Level-triggered sources simply mirror their line.
    w_pend_next = (w_pend_next & ~r_trig) | (irq_src & r_trig);
`endif
  end

  // Source-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_en   <= '0;
      r_prev <= '0;
    end else begin
      r_pend <= w_pend_next;
      r_prev <= irq_src;
      if (we && (a == A_ENABLE)) r_en <= w_wdata[NSRC-1:0];
    end
  end

`ifdef IRQ_LEVEL_MODE_EN
  always_ff @(posedge clk) begin
    if (rst)                          r_trig <= '0;
    else if (we && (a == A_TRIGMODE)) r_trig <= w_wdata[NSRC-1:0];
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_next = S_ASSERT;
      end
      S_ASSERT: begin
        if (w_claim)     w_state_next = S_SERVICE;
        else if (!w_any) w_state_next = S_IDLE;
      end
      S_SERVICE: begin
        if (w_complete) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: irq follows the ASSERT state one cycle later; isvc tracks the claim.
  always_comb begin
    w_irq_next  = (w_state_next == S_ASSERT);
    w_isvc_next = r_isvc;
    if (w_claim)    w_isvc_next = w_best_id;
    if (w_complete) w_isvc_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq  <= 1'b0;
      r_isvc <= '0;
    end else begin
      r_irq  <= w_irq_next;
      r_isvc <= w_isvc_next;
    end
  end

  assign irq = r_irq;

  // Read mux, pre-swap.
  always_comb begin
    w_rdata = '0;
    case (a)
      A_PENDING: w_rdata = 32'(r_pend);
      A_ENABLE:  w_rdata = 32'(r_en);
      A_CLAIM:   w_rdata = (r_state == S_ASSERT) ? 32'(w_best_id) : 32'd0;
      A_STATUS: begin
        w_rdata[IDW-1:0] = r_isvc;
        w_rdata[8]       = r_irq;
      end
`ifdef IRQ_LEVEL_MODE_EN
      A_TRIGMODE: w_rdata = 32'(r_trig);
`endif
      default: w_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Testbench for irq_arbiter: directed scenarios plus randomized traffic,
// checked against a behavioural model of the controller.
module tb_irq_arbiter;

  localparam int unsigned NSRC = 4;
  localparam logic [31:0] MASK = 32'h0000_000F;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      a;
  logic [31:0]     d;
  logic            we;
  logic            re;
  logic [31:0]     spo;
  logic [NSRC-1:0] irq_src;
  logic            irq;

  int checks   = 0;
  int failures = 0;

  // Model: pending/enable/trigger bit sets, last sampled lines,
  // "irq asserted" flag and in-service id (0 = nothing in service).
  logic [31:0] m_pend, m_en, m_prev, m_trig;
  int          m_isvc;
  bit          m_irq;

  irq_arbiter #(.NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .re(re),
    .spo(spo), .irq_src(irq_src), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic int m_best();
    for (int i = 0; i < int'(NSRC); i++)
      if (m_pend[i] && m_en[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_spo(input logic [2:0] sel);
    logic [31:0] v;
    v = 32'd0;
    case (sel)
      3'd0: v = m_pend;
      3'd1: v = m_en;
      3'd2: v = m_irq ? 32'(m_best()) : 32'd0;
      3'd3: v = 32'(m_isvc) | (m_irq ? 32'h100 : 32'h0);
      3'd4: v = m_trig;
      default: v = 32'd0;
    endcase
    return swap32(v);
  endfunction

  task automatic drive(input logic [2:0] ia, input logic [31:0] id,
                       input logic iwe, input logic ire, input logic [NSRC-1:0] isrc);
    a = ia; d = id; we = iwe; re = ire; irq_src = isrc;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic [31:0] v, clr, edg, np, nen, ntrig;
    int b, nisvc;
    bit nirq, claim;
    if (rst) begin
      np = 0; nen = 0; ntrig = 0; nisvc = 0; nirq = 0;
    end else begin
      v     = swap32(d);
      b     = m_best();
      claim = m_irq && re && (a == 3'd2) && (b != 0);
      clr   = (we && a == 3'd0) ? v : 32'd0;
      if (claim) clr = clr | (32'd1 << (b - 1));
      edg   = 32'(irq_src) & ~m_prev;
      np    = ((m_pend & ~clr) | edg) & MASK;
      np    = (np & ~m_trig) | (32'(irq_src) & m_trig);
      nen   = m_en;
      if (we && a == 3'd1) nen = v & MASK;
      ntrig = m_trig;
`ifdef IRQ_LEVEL_MODE_EN
      if (we && a == 3'd4) ntrig = v & MASK;
`endif
      nirq  = m_irq;
      nisvc = m_isvc;
      if (m_irq) begin
        if (claim) begin nisvc = b; nirq = 0; end
        else if (b == 0) nirq = 0;
      end else if (m_isvc != 0) begin
        if (we && a == 3'd2 && v == 32'(m_isvc)) nisvc = 0;
      end else if (b != 0) begin
        nirq = 1;
      end
    end
    @(posedge clk);
    #1;
    m_prev = rst ? 32'd0 : 32'(irq_src);
    m_pend = np; m_en = nen; m_trig = ntrig; m_isvc = nisvc; m_irq = nirq;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'd0, 32'd0, 1'b0, 1'b0, '0);
    tick(); tick();
    rst = 1'b0;
    drive(3'd0, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL reset_pending: got %h want 0", spo); end
    drive(3'd1, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL reset_enable: got %h want 0", spo); end
    drive(3'd3, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL reset_status: got %h want 0", spo); end
  endtask

  task automatic test_basic();
    drive(3'd1, swap32(32'd1), 1'b1, 1'b0, '0); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0001); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0000);
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL pend_after_pulse: got %h want %h", spo, swap32(32'd1)); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_one_cycle: got %b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_two_cycles: got %b want 1", irq); end
    drive(3'd2, 32'd0, 1'b0, 1'b1, '0);
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL claim_id1: got %h want %h", spo, swap32(32'd1)); end
    tick();
    drive(3'd3, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_claim: got %b want 0", irq); end
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL status_isvc: got %h want %h", spo, swap32(32'd1)); end
    drive(3'd2, swap32(32'd1), 1'b1, 1'b0, '0); tick();
    drive(3'd3, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL status_after_complete: got %h want 0", spo); end
  endtask

  task automatic test_priority();
    drive(3'd1, swap32(32'hF), 1'b1, 1'b0, '0); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0110); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0000); tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL prio_irq: got %b want 1", irq); end
    drive(3'd2, 32'd0, 1'b0, 1'b1, '0);
    checks++; if (spo !== swap32(32'd2)) begin failures++; $display("FAIL claim_prio: got %h want %h", spo, swap32(32'd2)); end
    tick();
    drive(3'd2, swap32(32'd2), 1'b1, 1'b0, '0); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, '0); tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_reassert: got %b want 1", irq); end
    drive(3'd2, 32'd0, 1'b0, 1'b1, '0);
    checks++; if (spo !== swap32(32'd3)) begin failures++; $display("FAIL claim_second: got %h want %h", spo, swap32(32'd3)); end
    tick();
    drive(3'd2, swap32(32'd3), 1'b1, 1'b0, '0); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, '0); tick();
  endtask

  task automatic test_bad_complete();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0001); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0000); tick();
    drive(3'd2, 32'd0, 1'b0, 1'b1, '0);
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL claim_src0: got %h want %h", spo, swap32(32'd1)); end
    tick();
    drive(3'd2, swap32(32'd5), 1'b1, 1'b0, 4'b0001); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0000); tick(); tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_held_service: got %b want 0", irq); end
    drive(3'd3, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL bad_complete_ignored: got %h want %h", spo, swap32(32'd1)); end
    drive(3'd2, swap32(32'd1), 1'b1, 1'b0, '0); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, '0); tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_after_complete: got %b want 1", irq); end
    drive(3'd2, 32'd0, 1'b0, 1'b1, '0); tick();
    drive(3'd2, swap32(32'd1), 1'b1, 1'b0, '0); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, '0); tick();
  endtask

  task automatic test_w1c_collision();
    drive(3'd1, 32'd0, 1'b1, 1'b0, '0); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0001); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0000); tick();
    drive(3'd0, swap32(32'd1), 1'b1, 1'b0, 4'b0001); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0000);
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL w1c_set_wins: got %h want %h", spo, swap32(32'd1)); end
    drive(3'd0, swap32(32'd1), 1'b1, 1'b0, '0); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL w1c_clear: got %h want 0", spo); end
  endtask

  task automatic test_reset_service();
    drive(3'd1, swap32(32'd1), 1'b1, 1'b0, 4'b0001); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0010); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0000); tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_rst_irq: got %b want 1", irq); end
    drive(3'd2, 32'd0, 1'b0, 1'b1, '0); tick();
    drive(3'd3, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL pre_rst_status: got %h want %h", spo, swap32(32'd1)); end
    rst = 1'b1; tick(); rst = 1'b0;
    drive(3'd0, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_service_irq: got %b want 0", irq); end
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL rst_service_pending: got %h want 0", spo); end
    drive(3'd1, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL rst_service_enable: got %h want 0", spo); end
    drive(3'd3, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL rst_service_status: got %h want 0", spo); end
  endtask

`ifdef IRQ_LEVEL_MODE_EN
  task automatic test_trigmode();
    rst = 1'b1; drive(3'd0, 32'd0, 1'b0, 1'b0, '0); tick(); rst = 1'b0;
    drive(3'd1, swap32(32'd1), 1'b1, 1'b0, '0); tick();
    drive(3'd4, swap32(32'd1), 1'b1, 1'b0, 4'b0001); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0001); tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_irq: got %b want 1", irq); end
    drive(3'd2, 32'd0, 1'b0, 1'b1, 4'b0001);
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL level_claim: got %h want %h", spo, swap32(32'd1)); end
    tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0001);
    checks++; if (spo !== swap32(32'd1)) begin failures++; $display("FAIL level_pend_held: got %h want %h", spo, swap32(32'd1)); end
    drive(3'd2, swap32(32'd1), 1'b1, 1'b0, 4'b0001); tick();
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0001); tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_reassert: got %b want 1", irq); end
    drive(3'd0, 32'd0, 1'b0, 1'b0, 4'b0000); tick();
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL level_drop_pend: got %h want 0", spo); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_drop_irq: got %b want 0", irq); end
  endtask
`else
  task automatic test_trigmode();
    drive(3'd4, swap32(32'hF), 1'b1, 1'b0, '0); tick();
    drive(3'd4, 32'd0, 1'b0, 1'b0, '0);
    checks++; if (spo !== 32'd0) begin failures++; $display("FAIL trigmode_absent: got %h want 0", spo); end
  endtask
`endif

  task automatic test_random();
    logic [2:0]      ra;
    logic [31:0]     rd;
    logic [NSRC-1:0] rs;
    rst = 1'b1; drive(3'd0, 32'd0, 1'b0, 1'b0, '0); tick(); rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      ra  = 3'($urandom_range(0, 4));
      rs  = NSRC'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      if (ra == 3'd2)
        rd = swap32(($urandom_range(0, 1) == 1) ? 32'(m_isvc) : 32'($urandom_range(0, 5)));
      else
        rd = swap32($urandom);
      drive(ra, rd, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), rs);
      checks++; if (spo !== m_spo(ra)) begin failures++; $display("FAIL rand_spo n=%0d a=%0d: got %h want %h", n, ra, spo, m_spo(ra)); end
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq n=%0d: got %b want %b", n, irq, m_irq); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_pend = 0; m_en = 0; m_prev = 0; m_trig = 0; m_isvc = 0; m_irq = 0;
    rst = 1'b1; a = '0; d = '0; we = 1'b0; re = 1'b0; irq_src = '0;
    test_reset();
    test_basic();
    test_priority();
    test_bad_complete();
    test_w1c_collision();
    test_reset_service();
    test_trigmode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
